// File: rtl/vol_sci_arb_pkg.sv
// Shared constants and encodings for the volume/SCI write arbiter.
// Mute support is enabled by defining VOL_MUTE_EN.
package vol_sci_arb_pkg;

    localparam logic [7:0]  SCI_VOL_ADDR = 8'h0B;
    localparam logic [15:0] MUTE_WORD    = 16'hFEFE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_CMD = 2'd1,
        ST_WR_VOL = 2'd2
    } state_e;

    typedef enum logic {
        SRV_VOL = 1'b0,
        SRV_CMD = 1'b1
    } srv_e;

    // Word actually sent to SCI_VOL for a given mute state.
    function automatic logic [15:0] vol_word(input logic muted, input logic [15:0] vol);
        if (muted) begin
            return MUTE_WORD;
        end else begin
            return vol;
        end
    endfunction

endpackage

// File: rtl/vol_sci_step.sv
// Saturating one-byte attenuation step: UP lowers, DOWN raises, both or
// neither leave the value untouched; chg_o flags an effective change.
module vol_sci_step
    import vol_sci_arb_pkg::*;
#(
    parameter logic [7:0] STEP = 8'h10,
    parameter logic [7:0] MAX  = 8'hF0
) (
    input  logic [7:0] cur_i,
    input  logic       up_i,
    input  logic       down_i,
    output logic [7:0] nxt_o,
    output logic       chg_o
);

    logic [8:0] sum_s;

    // Next byte value with floor 0 and ceiling MAX.
    always_comb begin
        sum_s = {1'b0, cur_i} + {1'b0, STEP};
        nxt_o = cur_i;
        if (up_i && !down_i) begin
            if (cur_i > STEP) begin
                nxt_o = cur_i - STEP;
            end else begin
                nxt_o = 8'h00;
            end
        end else if (down_i && !up_i) begin
            if (sum_s > {1'b0, MAX}) begin
                nxt_o = MAX;
            end else begin
                nxt_o = sum_s[7:0];
            end
        end else begin
            nxt_o = cur_i;
        end
        chg_o = (nxt_o != cur_i);
    end

endmodule

// File: rtl/vol_sci_arb.sv
// Volume register plus round-robin arbiter sharing one SCI master between
// volume writes and external commands. Optional mute: define VOL_MUTE_EN.
module vol_sci_arb
    import vol_sci_arb_pkg::*;
#(
    parameter logic [15:0] VOL_INIT = 16'hF0F0,
    parameter logic [7:0]  VOL_STEP = 8'h10,
    parameter logic [7:0]  VOL_MAX  = 8'hF0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        UP,
    input  logic        DOWN,
    input  logic        MUTE,
    input  logic        CMD_REQ,
    input  logic [7:0]  CMD_ADDR,
    input  logic [15:0] CMD_DATA,
    output logic        CMD_ACK,
    output logic        SCI_REQ,
    output logic [7:0]  SCI_ADDR,
    output logic [15:0] SCI_WDATA,
    input  logic        SCI_DONE,
    output logic [15:0] VOL,
    output logic        VOL_MUTED,
    output logic        BUSY
);

    state_e      state_q, state_d;
    srv_e        last_q, last_d;
    logic [15:0] vol_q, vol_d;
    logic        dirty_q, dirty_d;
    logic        sci_req_q, sci_req_d;
    logic [7:0]  sci_addr_q, sci_addr_d;
    logic [15:0] sci_wdata_q, sci_wdata_d;
    logic        cmd_ack_q, cmd_ack_d;
    logic        busy_q, busy_d;

    logic [7:0]  hi_nxt_s, lo_nxt_s;
    logic        hi_chg_s, lo_chg_s;
    logic        vol_chg_s;
    logic        mute_chg_s;
    logic        muted_s;
    logic        chg_s;
    logic        cmd_pend_s;

    vol_sci_step #(.STEP(VOL_STEP), .MAX(VOL_MAX)) u_step_hi (
        .cur_i  (vol_q[15:8]),
        .up_i   (UP),
        .down_i (DOWN),
        .nxt_o  (hi_nxt_s),
        .chg_o  (hi_chg_s)
    );

    vol_sci_step #(.STEP(VOL_STEP), .MAX(VOL_MAX)) u_step_lo (
        .cur_i  (vol_q[7:0]),
        .up_i   (UP),
        .down_i (DOWN),
        .nxt_o  (lo_nxt_s),
        .chg_o  (lo_chg_s)
    );

`ifdef VOL_MUTE_EN
    logic mute_q, mute_d;

    // Mute toggles on every MUTE pulse.
    always_comb begin
        if (MUTE) begin
            mute_d = !mute_q;
        end else begin
            mute_d = mute_q;
        end
    end

    // Mute state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mute_q <= 1'b0;
        end else begin
            mute_q <= mute_d;
        end
    end

    assign muted_s    = mute_q;
    assign mute_chg_s = MUTE;
`else
    logic unused_mute_s;

    assign unused_mute_s = MUTE;
    assign muted_s       = 1'b0;
    assign mute_chg_s    = 1'b0;
`endif

    // Volume next state and change detection.
    always_comb begin
        vol_d     = {hi_nxt_s, lo_nxt_s};
        vol_chg_s = hi_chg_s | lo_chg_s;
        chg_s     = vol_chg_s | mute_chg_s;
    end

    // Arbitration and write FSM. A change landing on the grant cycle keeps
    // the dirty flag so the newer value is written afterwards.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        dirty_d     = dirty_q | chg_s;
        sci_req_d   = sci_req_q;
        sci_addr_d  = sci_addr_q;
        sci_wdata_d = sci_wdata_q;
        cmd_ack_d   = 1'b0;
        // The requester still holds CMD_REQ during its ACK cycle.
        cmd_pend_s  = CMD_REQ && !cmd_ack_q;
        case (state_q)
            ST_IDLE: begin
                if (dirty_q && (!cmd_pend_s || (last_q == SRV_CMD))) begin
                    state_d     = ST_WR_VOL;
                    last_d      = SRV_VOL;
                    dirty_d     = chg_s;
                    sci_req_d   = 1'b1;
                    sci_addr_d  = SCI_VOL_ADDR;
                    sci_wdata_d = vol_word(muted_s, vol_q);
                end else if (cmd_pend_s) begin
                    state_d     = ST_WR_CMD;
                    last_d      = SRV_CMD;
                    sci_req_d   = 1'b1;
                    sci_addr_d  = CMD_ADDR;
                    sci_wdata_d = CMD_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_CMD: begin
                if (SCI_DONE) begin
                    state_d   = ST_IDLE;
                    sci_req_d = 1'b0;
                    cmd_ack_d = 1'b1;
                end else begin
                    state_d = ST_WR_CMD;
                end
            end
            ST_WR_VOL: begin
                if (SCI_DONE) begin
                    state_d   = ST_IDLE;
                    sci_req_d = 1'b0;
                end else begin
                    state_d = ST_WR_VOL;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                sci_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, volume and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            last_q      <= SRV_CMD;
            vol_q       <= VOL_INIT;
            dirty_q     <= 1'b1;
            sci_req_q   <= 1'b0;
            sci_addr_q  <= 8'h00;
            sci_wdata_q <= 16'h0000;
            cmd_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            vol_q       <= vol_d;
            dirty_q     <= dirty_d;
            sci_req_q   <= sci_req_d;
            sci_addr_q  <= sci_addr_d;
            sci_wdata_q <= sci_wdata_d;
            cmd_ack_q   <= cmd_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign CMD_ACK   = cmd_ack_q;
    assign SCI_REQ   = sci_req_q;
    assign SCI_ADDR  = sci_addr_q;
    assign SCI_WDATA = sci_wdata_q;
    assign VOL       = vol_q;
    assign VOL_MUTED = muted_s;
    assign BUSY      = busy_q;

endmodule
